// File: rtl/mc_latency_responder_if.sv
// MC request/response port bundle between a requester (master) and the
// memory-controller responder (slave).
`timescale 1ns/1ps
interface mc_latency_responder_if #(
  parameter int MC_RTNCTL_WIDTH = 32
);
  logic                       mc_rq_vld;
  logic [2:0]                 mc_rq_cmd;
  logic [3:0]                 mc_rq_scmd;
  logic [47:0]                mc_rq_vadr;
  logic [1:0]                 mc_rq_size;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic [63:0]                mc_rq_data;
  logic                       mc_rq_flush;
  logic                       mc_rq_stall;
  logic                       mc_rs_vld;
  logic [2:0]                 mc_rs_cmd;
  logic [3:0]                 mc_rs_scmd;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic [63:0]                mc_rs_data;
  logic                       mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data
  );
endinterface

// File: rtl/mc_latency_responder.sv
// Memory-controller responder model: word RAM serviced at accept, fixed-latency
// pipeline into an ordered response FIFO, with credit-style request stall.
`timescale 1ns/1ps
module mc_latency_responder #(
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int RAM_DEPTH       = 512,
  parameter int LATENCY         = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int STALL_SLACK     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mc_latency_responder_if.slave mc,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  err
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - STALL_SLACK);

  typedef struct packed {
    logic                       vld;
    logic [2:0]                 cmd;
    logic [3:0]                 scmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]                data;
  } entry_t;

  logic [63:0]   ram [RAM_DEPTH];
  entry_t        pipe [LATENCY];
  entry_t        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, occ, occ_next;
  entry_t        new_entry, rs_q;
  logic          stall_q;

  logic [AW-1:0] widx;
  logic          fmt_ok, req_ok, has_room, accept, flush_in, enter;
  logic          push, pop, err_evt;
  logic          unused_vadr;

  assign widx        = mc.mc_rq_vadr[3 +: AW];
  assign unused_vadr = ^{mc.mc_rq_vadr[2:0], mc.mc_rq_vadr[47:3+AW]};

  assign fmt_ok   = ((mc.mc_rq_cmd == 3'd1) || (mc.mc_rq_cmd == 3'd2)) && (mc.mc_rq_size == 2'd3);
  assign req_ok   = mc.mc_rq_vld && fmt_ok;
  assign has_room = (occ < FULL);
  assign accept   = req_ok && has_room;
  assign flush_in = mc.mc_rq_flush && !mc.mc_rq_vld && has_room;
  assign enter    = accept || flush_in;
  assign push     = pipe[LATENCY-1].vld;
  assign pop      = (fifo_cnt != '0) && !mc.mc_rs_stall;
  assign occ_next = occ + CW'(enter) - CW'(pop);

  // A flush that finds no room is lost, so it is flagged like an overflow.
  assign err_evt = (mc.mc_rq_vld && mc.mc_rq_flush)
                || (mc.mc_rq_vld && !fmt_ok)
                || (req_ok && !has_room)
                || (mc.mc_rq_flush && !mc.mc_rq_vld && !has_room);

  always_comb begin
    new_entry = '0;
    if (accept) begin
      new_entry.vld    = 1'b1;
      new_entry.scmd   = mc.mc_rq_scmd;
      new_entry.rtnctl = mc.mc_rq_rtnctl;
      if (mc.mc_rq_cmd == 3'd1) begin
        new_entry.cmd  = 3'd2;
        new_entry.data = ram[widx];
      end else begin
        new_entry.cmd  = 3'd3;
      end
    end else if (flush_in) begin
      new_entry.vld = 1'b1;
      new_entry.cmd = 3'd7;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (accept && (mc.mc_rq_cmd == 3'd2))
      ram[widx] <= mc.mc_rq_data;
    if (push)
      fifo_mem[wr_ptr] <= pipe[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= new_entry;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
      stall_q  <= 1'b0;
      rs_q     <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      occ      <= occ_next;
      stall_q  <= (occ_next >= STALL_AT);
      if (pop) rs_q <= fifo_mem[rd_ptr];
      else     rs_q.vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && (mc.mc_rq_cmd == 3'd1)) rd_count <= rd_count + 32'd1;
      if (accept && (mc.mc_rq_cmd == 3'd2)) wr_count <= wr_count + 32'd1;
      if (err_evt) err <= 1'b1;
    end
  end

  assign mc.mc_rq_stall  = stall_q;
  assign mc.mc_rs_vld    = rs_q.vld;
  assign mc.mc_rs_cmd    = rs_q.cmd;
  assign mc.mc_rs_scmd   = rs_q.scmd;
  assign mc.mc_rs_rtnctl = rs_q.rtnctl;
  assign mc.mc_rs_data   = rs_q.data;
endmodule

// File: tb/tb_mc_latency_responder.sv
// Directed bench for mc_latency_responder: responses are collected with their
// cycle stamp and compared against hand-computed tags, data and latencies.
`timescale 1ns/1ps
module tb_mc_latency_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd_count, wr_count;
  logic        err;

  always #5 clk = ~clk;

  mc_latency_responder_if #(.MC_RTNCTL_WIDTH(32)) bus ();

  mc_latency_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mc       (bus),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err      (err)
  );

  typedef struct {
    int          t;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [31:0] rtn;
    logic [63:0] data;
  } rsp_t;

  rsp_t rsq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk)
    if (rst_n && bus.mc_rs_vld)
      rsq.push_back('{cyc, bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data});

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one request cycle starting at a falling edge; acc_cyc is the edge that sampled it.
  task automatic applyStimulus(input logic vld, input logic flush, input logic [2:0] cmd,
                               input logic [1:0] size, input logic [3:0] scmd,
                               input logic [47:0] vadr, input logic [31:0] rtn,
                               input logic [63:0] data);
    bus.mc_rq_vld    = vld;
    bus.mc_rq_flush  = flush;
    bus.mc_rq_cmd    = cmd;
    bus.mc_rq_size   = size;
    bus.mc_rq_scmd   = scmd;
    bus.mc_rq_vadr   = vadr;
    bus.mc_rq_rtnctl = rtn;
    bus.mc_rq_data   = data;
    @(negedge clk);
    acc_cyc = cyc;
    bus.mc_rq_vld   = 1'b0;
    bus.mc_rq_flush = 1'b0;
  endtask

  task automatic rd_req(input logic [47:0] vadr, input logic [31:0] rtn);
    applyStimulus(1'b1, 1'b0, 3'd1, 2'd3, 4'd0, vadr, rtn, 64'd0);
  endtask

  task automatic wr_req(input logic [47:0] vadr, input logic [31:0] rtn, input logic [63:0] data,
                        input logic [3:0] scmd);
    applyStimulus(1'b1, 1'b0, 3'd2, 2'd3, scmd, vadr, rtn, data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input int idx, input logic [2:0] cmd,
                           input logic [3:0] scmd, input logic [31:0] rtn, input logic [63:0] data);
    if (idx >= rsq.size()) begin
      checkOutput({tag, "_present"}, 64'(rsq.size()), 64'(idx + 1));
    end else begin
      checkOutput({tag, "_cmd"}, 64'(rsq[idx].cmd), 64'(cmd));
      checkOutput({tag, "_scmd"}, 64'(rsq[idx].scmd), 64'(scmd));
      checkOutput({tag, "_rtnctl"}, 64'(rsq[idx].rtn), 64'(rtn));
      checkOutput({tag, "_data"}, rsq[idx].data, data);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rsq.delete();
    rst_n = 1'b1;
    idle(1);
  endtask

  int t_w, t_r, t_f;

  initial begin
    rst_n = 1'b0;
    bus.mc_rs_stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 48'd0, 32'd0, 64'd0);
    idle(2);
    checkOutput("rst_rq_stall", 64'(bus.mc_rq_stall), 64'd0);
    checkOutput("rst_rs_vld", 64'(bus.mc_rs_vld), 64'd0);
    checkOutput("rst_rd_count", 64'(rd_count), 64'd0);
    checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] write then read of one word");
    wr_req(48'h40, 32'h11, 64'hDEADBEEF_00000001, 4'd5);
    t_w = acc_cyc;
    rd_req(48'h40, 32'h22);
    t_r = acc_cyc;
    idle(15);
    checkOutput("wr_rd_count", 64'(rsq.size()), 64'd2);
    check_rsp("wr_rsp", 0, 3'd3, 4'd5, 32'h11, 64'd0);
    check_rsp("rd_rsp", 1, 3'd2, 4'd0, 32'h22, 64'hDEADBEEF_00000001);
    if (rsq.size() >= 2) begin
      checkOutput("wr_latency", 64'(rsq[0].t - t_w), 64'd9);
      checkOutput("rd_latency", 64'(rsq[1].t - t_r), 64'd9);
    end
    checkOutput("wr_count_1", 64'(wr_count), 64'd1);
    checkOutput("rd_count_1", 64'(rd_count), 64'd1);
    rsq.delete();

    $display("[TB] address aliasing");
    wr_req(48'h1008, 32'h3, 64'h01234567_89ABCDEF, 4'd0);
    rd_req(48'h0008, 32'h4);
    idle(15);
    check_rsp("alias_rd", 1, 3'd2, 4'd0, 32'h4, 64'h01234567_89ABCDEF);
    rsq.delete();

    $display("[TB] flush ordering");
    wr_req(48'h100, 32'h31, 64'hA1, 4'd1);
    t_w = acc_cyc;
    wr_req(48'h108, 32'h32, 64'hA2, 4'd2);
    wr_req(48'h110, 32'h33, 64'hA3, 4'd3);
    applyStimulus(1'b0, 1'b1, 3'd0, 2'd3, 4'd9, 48'h0, 32'h99, 64'h77);
    t_f = acc_cyc;
    idle(5);
    checkOutput("flush_no_early_rsp", 64'(rsq.size()), 64'd0);
    idle(10);
    checkOutput("flush_rsp_count", 64'(rsq.size()), 64'd4);
    check_rsp("flush_w0", 0, 3'd3, 4'd1, 32'h31, 64'd0);
    check_rsp("flush_w1", 1, 3'd3, 4'd2, 32'h32, 64'd0);
    check_rsp("flush_w2", 2, 3'd3, 4'd3, 32'h33, 64'd0);
    check_rsp("flush_f", 3, 3'd7, 4'd0, 32'h0, 64'd0);
    if (rsq.size() >= 4) begin
      checkOutput("flush_w0_latency", 64'(rsq[0].t - t_w), 64'd9);
      checkOutput("flush_latency", 64'(rsq[3].t - t_f), 64'd9);
    end
    checkOutput("flush_wr_count", 64'(wr_count), 64'd5);
    checkOutput("flush_err", 64'(err), 64'd0);
    rsq.delete();

    $display("[TB] credit stall and overflow");
    bus.mc_rs_stall = 1'b1;
    for (int i = 0; i < 13; i++) rd_req(48'h40, 32'(100 + i));
    checkOutput("stall_after_13", 64'(bus.mc_rq_stall), 64'd0);
    rd_req(48'h40, 32'd113);
    checkOutput("stall_after_14", 64'(bus.mc_rq_stall), 64'd1);
    rd_req(48'h40, 32'd114);
    rd_req(48'h40, 32'd115);
    checkOutput("err_before_overflow", 64'(err), 64'd0);
    rd_req(48'h40, 32'd116);
    checkOutput("err_after_overflow", 64'(err), 64'd1);
    checkOutput("rd_count_overflow", 64'(rd_count), 64'd18);
    idle(10);
    checkOutput("no_rsp_while_stalled", 64'(rsq.size()), 64'd0);
    bus.mc_rs_stall = 1'b0;
    idle(25);
    checkOutput("stall_rsp_count", 64'(rsq.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      check_rsp($sformatf("stall_rsp%0d", i), i, 3'd2, 4'd0, 32'(100 + i), 64'hDEADBEEF_00000001);
    checkOutput("stall_released", 64'(bus.mc_rq_stall), 64'd0);
    rsq.delete();

    $display("[TB] reset with requests in flight");
    for (int i = 0; i < 5; i++) rd_req(48'h40, 32'(200 + i));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rs_vld", 64'(bus.mc_rs_vld), 64'd0);
    checkOutput("midrst_rd_count", 64'(rd_count), 64'd0);
    checkOutput("midrst_err", 64'(err), 64'd0);
    idle(2);
    rsq.delete();
    rst_n = 1'b1;
    idle(15);
    checkOutput("midrst_no_rsp", 64'(rsq.size()), 64'd0);
    rd_req(48'h40, 32'h51);
    rd_req(48'h08, 32'h52);
    idle(15);
    check_rsp("ram_kept_40", 0, 3'd2, 4'd0, 32'h51, 64'hDEADBEEF_00000001);
    check_rsp("ram_kept_08", 1, 3'd2, 4'd0, 32'h52, 64'h01234567_89ABCDEF);
    checkOutput("post_rst_rd_count", 64'(rd_count), 64'd2);
    rsq.delete();

    $display("[TB] unsupported requests");
    applyStimulus(1'b1, 1'b0, 3'd4, 2'd3, 4'd0, 48'h40, 32'h61, 64'h0);
    checkOutput("badcmd_err", 64'(err), 64'd1);
    checkOutput("badcmd_rd_count", 64'(rd_count), 64'd2);
    checkOutput("badcmd_wr_count", 64'(wr_count), 64'd0);
    idle(15);
    checkOutput("badcmd_no_rsp", 64'(rsq.size()), 64'd0);
    do_reset();
    applyStimulus(1'b1, 1'b0, 3'd1, 2'd2, 4'd0, 48'h40, 32'h62, 64'h0);
    checkOutput("badsize_err", 64'(err), 64'd1);
    checkOutput("badsize_rd_count", 64'(rd_count), 64'd0);
    idle(15);
    checkOutput("badsize_no_rsp", 64'(rsq.size()), 64'd0);
    do_reset();
    applyStimulus(1'b1, 1'b1, 3'd2, 2'd3, 4'd0, 48'h200, 32'h71, 64'h5555);
    checkOutput("vldflush_err", 64'(err), 64'd1);
    checkOutput("vldflush_wr_count", 64'(wr_count), 64'd1);
    idle(15);
    checkOutput("vldflush_rsp_count", 64'(rsq.size()), 64'd1);
    check_rsp("vldflush_rsp", 0, 3'd3, 4'd0, 32'h71, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_latency_responder.md
Name: mc_latency_responder

Overview:
Synthesizable memory-controller responder model; it sits on the responder side of the MC request/response port. It accepts read, write and flush requests from a requester such as phold and services them from an internal word RAM. After a fixed pipeline latency it returns ordered responses through a response FIFO. It honours response-side stall and drives credit-based request stall, so simulation and FPGA bring-up can run without the platform memory controller.

Parameters:
MC_RTNCTL_WIDTH, 32, width of rtnctl tag echoed in responses
RAM_DEPTH, 512, number of 64-bit words; power of two
LATENCY, 8, request-to-FIFO-entry delay in cycles; minimum 1
FIFO_DEPTH, 16, response FIFO entries; power of two; must be at least LATENCY+STALL_SLACK
STALL_SLACK, 2, requests the requester may still issue after seeing mc_rq_stall

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mc_rq_vld  in  1  request valid
mc_rq_cmd  in  3  1=read, 2=write; other values unsupported
mc_rq_scmd  in  4  sub-command; echoed in response
mc_rq_vadr  in  48  byte address; word index = vadr[3 +: log2(RAM_DEPTH)]
mc_rq_size  in  2  must be 3 (8 bytes)
mc_rq_rtnctl  in  MC_RTNCTL_WIDTH  tag echoed in response
mc_rq_data  in  64  write data
mc_rq_flush  in  1  flush request
mc_rq_stall  out  1  requester must stop issuing
mc_rs_vld  out  1  response valid
mc_rs_cmd  out  3  2=read data, 3=write complete, 7=flush complete
mc_rs_scmd  out  4  echoed scmd
mc_rs_rtnctl  out  MC_RTNCTL_WIDTH  echoed tag
mc_rs_data  out  64  read data; 0 for write and flush responses
mc_rs_stall  in  1  consumer stall
rd_count  out  32  reads accepted
wr_count  out  32  writes accepted
err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including mc_rq_stall, mc_rs_vld, counters and err. FIFO and pipeline are emptied. RAM contents are not cleared. Reset asserted mid-operation discards all in-flight requests with no response.
- Acceptance: a request is accepted in every cycle with mc_rq_vld=1, cmd in {1,2}, size=3, and occupancy < FIFO_DEPTH.
- occupancy = FIFO entries + pipeline valid stages.
- Write: RAM is updated at the accept edge; response cmd=3.
- Read: RAM is read at the accept edge; response cmd=2 with data as RAM held before any same-cycle write (there is only one port, so no same-cycle hazard exists).
- Accepted request enters LATENCY-stage shift register (valid, cmd, scmd, rtnctl, data). Stage output is pushed to the FIFO LATENCY cycles after accept.
- Flush: with mc_rq_flush=1 and mc_rq_vld=0, a flush pseudo-entry (cmd=7, scmd=0, rtnctl=0, data=0) enters the pipeline. It is ordered after every earlier request.
- Flush and vld in the same cycle: request is accepted, flush is ignored, err set.
- Unsupported cmd or size with vld=1: no response, no RAM change, err set.
- Overflow: vld=1 with occupancy == FIFO_DEPTH: request dropped, err set.
- mc_rq_stall is a registered output = (occupancy_next >= FIFO_DEPTH - STALL_SLACK). It deasserts when occupancy falls below that threshold.
- Response output: mc_rs_* are registered. In a cycle where FIFO is non-empty and mc_rs_stall=0, head is popped and presented with mc_rs_vld=1 on the next edge. Otherwise mc_rs_vld=0 next cycle.
- Responses leave strictly in acceptance order. Minimum accept-to-mc_rs_vld latency is LATENCY+1 cycles.
- A push and a pop in the same cycle are both performed; occupancy accounts for both.
- Counters are 32-bit, wrap at 2^32, and increment on accepted requests only.

Test Plan:
- Write 0xDEADBEEF_00000001 to vadr 0x40 with rtnctl 0x11, then read vadr 0x40 with rtnctl 0x22 -> cmd=3 rtnctl=0x11 at accept+9, then cmd=2 data=0xDEADBEEF_00000001 rtnctl=0x22; wr_count=1, rd_count=1.
- Address aliasing: write vadr 0x1008 with RAM_DEPTH=512 -> read of vadr 0x0008 returns the same data.
- mc_rs_stall held high, issue 14 back-to-back reads -> mc_rq_stall=1 the cycle after the 14th accept; 2 further reads accepted; a 17th is dropped with err=1; after stall release, 16 responses in order, then mc_rq_stall=0.
- Flush after 3 writes -> three cmd=3 responses then one cmd=7; no response before LATENCY+1 cycles.
- cmd=4, or size=2 with vld=1 -> no response, err=1, counters unchanged.
- Assert rst_n low with 5 requests in flight -> mc_rs_vld=0 immediately and no responses after release; RAM data written before reset is still readable.
